// File: rtl/odd_one_out_source.sv
// Odd-one-out stream source.
// Each test streams K LFSR values, then one unpaired value, then the K values
// again in reverse order. It then waits for the sink's answer and grades it
// against the unpaired value.
module odd_one_out_source #(
  parameter int MAX_PAIRS = 127,
  parameter int TIMEOUT   = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] seed,
  input  logic [6:0] pair_count,
  output logic [7:0] integers,
  output logic [7:0] N,
  output logic       latch_in,
  input  logic [7:0] out_value,
  input  logic       ready,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic [7:0] expected
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SEND_FWD,
    S_SEND_ODD,
    S_SEND_REV,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    k_q;        // pair count of the running test
  logic [6:0]    k_sat;      // pair_count clamped to MAX_PAIRS
  logic [6:0]    idx_q;      // write pointer going forward, read pointer going back
  logic [6:0]    rd_idx;
  logic [7:0]    lfsr_q;     // value to be sent next in the forward/odd phase
  logic [7:0]    seed_eff;
  logic [TW-1:0] wait_cnt;
  logic          start_ok;
  logic          wait_last;
  logic [7:0]    buffer [0:MAX_PAIRS-1];

  // Galois LFSR, right shift, taps 0xB8; the all-zero state is never reached.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  assign k_sat     = (pair_count > 7'(MAX_PAIRS)) ? 7'(MAX_PAIRS) : pair_count;
  assign seed_eff  = (seed == 8'h00) ? 8'h01 : seed;
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  // WAIT lasts at most TIMEOUT cycles; this is the last of them.
  assign wait_last = (wait_cnt == TW'(TIMEOUT - 1));
  // After the forward phase idx_q == K, so idx_q-1 walks K-1 down to 0.
  assign rd_idx    = idx_q - 7'd1;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_LATCH;
      S_LATCH:    state_d = (k_q != 7'd0) ? S_SEND_FWD : S_SEND_ODD;
      S_SEND_FWD: if (idx_q == k_q) state_d = S_SEND_ODD;
      S_SEND_ODD: state_d = (k_q != 7'd0) ? S_SEND_REV : S_WAIT;
      S_SEND_REV: if (idx_q == 7'd0) state_d = S_WAIT;
      S_WAIT:     if (ready || wait_last) state_d = S_DONE;
      S_DONE:     if (start) state_d = S_LATCH;
      default:    state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    latch_in = 1'b0;
    case (state_q)
      S_LATCH: begin
        busy     = 1'b1;
        latch_in = 1'b1;
      end
      S_SEND_FWD, S_SEND_ODD, S_SEND_REV, S_WAIT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath. Registered stream data is loaded on the edge that enters each
  // send state, so it is valid throughout that state's cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      integers <= 8'h00;
      N        <= 8'h00;
      expected <= 8'h00;
      pass     <= 1'b0;
      timeout  <= 1'b0;
      k_q      <= 7'd0;
      idx_q    <= 7'd0;
      lfsr_q   <= 8'h01;
      wait_cnt <= '0;
    end else begin
      integers <= 8'h00;
      wait_cnt <= (state_q == S_WAIT) ? wait_cnt + TW'(1) : '0;

      if (start_ok) begin
        k_q     <= k_sat;
        lfsr_q  <= seed_eff;
        N       <= {k_sat, 1'b1};
        idx_q   <= 7'd0;
        pass    <= 1'b0;
        timeout <= 1'b0;
      end

      case (state_d)
        S_SEND_FWD: begin
          integers <= lfsr_q;
          lfsr_q   <= lfsr_step(lfsr_q);
          idx_q    <= idx_q + 7'd1;
        end
        S_SEND_ODD: begin
          integers <= lfsr_q;
          expected <= lfsr_q;
        end
        S_SEND_REV: begin
          integers <= buffer[rd_idx];
          idx_q    <= rd_idx;
        end
        default: ;
      endcase

      // Grade the sink; a ready in the final WAIT cycle still counts.
      if ((state_q == S_WAIT) && (state_d == S_DONE)) begin
        pass    <= ready && (out_value == expected);
        timeout <= !ready;
      end
    end
  end

  // Pair buffer, written once per forward cycle.
  // NOTE: the buffer has no reset; every entry read back was written earlier in the same test.
  always_ff @(posedge clk) begin
    if (!reset && (state_d == S_SEND_FWD)) buffer[idx_q] <= lfsr_q;
  end

endmodule

// File: tb/tb_odd_one_out_source.sv
// Self-checking bench for odd_one_out_source: table-driven tests plus
// hand-written reset, timeout and saturation sequences.
module tb_odd_one_out_source;

  localparam int TIMEOUT_TB = 1023;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] seed;
  logic [6:0] pair_count;
  logic [7:0] integers;
  logic [7:0] N;
  logic       latch_in;
  logic [7:0] out_value;
  logic       ready;
  logic       busy;
  logic       done;
  logic       pass;
  logic       timeout;
  logic [7:0] expected;

  // Second instance with a small buffer to exercise pair_count saturation.
  logic       a_start;
  logic [7:0] a_integers;
  logic [7:0] a_n;
  logic       a_latch_in;
  logic       a_ready;
  logic       a_busy;
  logic       a_done;
  logic       a_pass;
  logic       a_timeout;
  logic [7:0] a_expected;

  int n_total = 0;
  int n_pass  = 0;

  odd_one_out_source #(.MAX_PAIRS(127), .TIMEOUT(TIMEOUT_TB)) u_dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .pair_count(pair_count),
    .integers(integers), .N(N), .latch_in(latch_in), .out_value(out_value),
    .ready(ready), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .expected(expected)
  );

  odd_one_out_source #(.MAX_PAIRS(4), .TIMEOUT(15)) u_sat (
    .clk(clk), .reset(reset), .start(a_start), .seed(seed), .pair_count(pair_count),
    .integers(a_integers), .N(a_n), .latch_in(a_latch_in), .out_value(out_value),
    .ready(a_ready), .busy(a_busy), .done(a_done), .pass(a_pass), .timeout(a_timeout),
    .expected(a_expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    else n_pass++;
  endtask

  function automatic logic [7:0] model_step(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  // mode: 0 = sink answers with XOR of received stream, 1 = fixed value, 2 = never ready.
  typedef struct {
    int         k;
    logic [7:0] seed;
    int         mode;
    logic [7:0] fixed_val;
    int         rdelay;
    bit         early;
    int         exp_n;
    int         exp_odd;   // -1 when not hand-computed
    int         exp_pass;
  } vec_t;

  // Called at a negedge with the DUT in IDLE or DONE; returns at a negedge in DONE.
  task automatic run_test(input vec_t v);
    logic [7:0] s;
    logic [7:0] fwd [$];
    logic [7:0] stream [$];
    logic [7:0] acc;
    logic [7:0] sink_val;
    int         c;
    s = (v.seed == 8'h00) ? 8'h01 : v.seed;
    for (int i = 0; i < v.k; i++) begin
      fwd.push_back(s);
      s = model_step(s);
    end
    stream = fwd;
    stream.push_back(s);
    for (int i = v.k - 1; i >= 0; i--) stream.push_back(fwd[i]);

    pair_count = 7'(v.k);
    seed       = v.seed;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("latch_in", latch_in, 1);
    check("N", N, v.exp_n);
    check("done_drop", done, 0);
    check("busy_latch", busy, 1);
    // Early ready carries a wrong answer; it must be ignored before WAIT.
    ready     = v.early;
    out_value = ~s;
    acc       = 8'h00;
    for (int i = 0; i < stream.size(); i++) begin
      @(negedge clk);
      check($sformatf("stream[%0d]", i), integers, stream[i]);
      if (i == 0) check("latch_pulse", latch_in, 0);
      acc ^= integers;
    end
    @(negedge clk);
    check("wait_data_zero", integers, 0);
    check("busy_wait", busy, 1);
    check("stream_xor", acc, expected);
    if (v.exp_odd >= 0) check("expected_hand", expected, v.exp_odd);

    sink_val = (v.mode == 1) ? v.fixed_val : acc;
    c = 0;
    while (c < 1100) begin
      if (done) break;
      ready     = (v.mode != 2) && (c == v.rdelay);
      out_value = sink_val;
      @(negedge clk);
      c++;
    end
    ready = 1'b0;
    check("done_latency", c, (v.mode == 2) ? TIMEOUT_TB : v.rdelay + 1);
    check("done", done, 1);
    check("busy_done", busy, 0);
    check("pass", pass, v.exp_pass);
    check("timeout", timeout, v.mode == 2);
    check("expected_held", expected, s);
  endtask

  vec_t       vecs [6];
  logic [7:0] a_exp [9];

  initial begin
    int c;
    vecs[0] = '{0,   8'h01, 1, 8'h01, 0, 1'b0, 1,   'h01, 1};
    vecs[1] = '{2,   8'h01, 1, 8'h5C, 1, 1'b0, 5,   'h5C, 1};
    vecs[2] = '{1,   8'h00, 1, 8'h00, 2, 1'b0, 3,   'hB8, 0};
    vecs[3] = '{3,   8'h01, 0, 8'h00, 0, 1'b1, 7,   'h2E, 1};
    vecs[4] = '{4,   8'h02, 0, 8'h00, 3, 1'b0, 9,   'h2E, 1};
    vecs[5] = '{127, 8'h5A, 0, 8'h00, 1, 1'b0, 255, -1,   1};
    a_exp   = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'h2E, 8'h5C, 8'hB8, 8'h01};

    reset = 1'b1; start = 1'b0; seed = 8'h00; pair_count = 7'd0;
    ready = 1'b0; out_value = 8'h00; a_start = 1'b0; a_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_integers", integers, 0);
    check("rst_N", N, 0);
    check("rst_latch_in", latch_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_timeout", timeout, 0);
    check("rst_expected", expected, 0);
    reset = 1'b0;
    @(negedge clk);

    // Table vectors; consecutive tests also start back-to-back from DONE.
    for (int i = 0; i < 6; i++) run_test(vecs[i]);

    // Reset in the middle of the forward phase (K=5).
    pair_count = 7'd5; seed = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_integers", integers, 0);
    check("mid_rst_N", N, 0);
    check("mid_rst_latch_in", latch_in, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_pass", pass, 0);
    check("mid_rst_timeout", timeout, 0);
    check("mid_rst_expected", expected, 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_latch_in", latch_in, 0);
      check("post_rst_integers", integers, 0);
      check("post_rst_busy", busy, 0);
    end
    run_test('{5, 8'h01, 0, 8'h00, 0, 1'b0, 11, 'hB3, 1});

    // Sink never answers: done exactly TIMEOUT cycles after entering WAIT.
    run_test('{1, 8'h03, 2, 8'h00, 0, 1'b0, 3, 'hB9, 0});
    // Ready in the final WAIT cycle wins over the timeout.
    run_test('{0, 8'h07, 0, 8'h00, TIMEOUT_TB - 1, 1'b0, 1, 'h07, 1});

    // Saturation: pair_count 127 on a MAX_PAIRS=4 instance gives N=9.
    seed = 8'h01; pair_count = 7'd127; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check("sat_latch_in", a_latch_in, 1);
    check("sat_N", a_n, 9);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("sat_stream[%0d]", i), a_integers, a_exp[i]);
    end
    @(negedge clk);
    c = 0;
    while (!a_done && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("sat_done_latency", c, 15);
    check("sat_timeout", a_timeout, 1);
    check("sat_pass", a_pass, 0);
    check("sat_expected", a_expected, 8'h17);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
